// File: rtl/tt3_pkg.sv
// Shared definitions for the 3-input truth-table sweep checker.
//   state_t      : sweep controller states
//   TT_W / VEC_W : truth-table width and stimulus vector width
//   tt_mismatch  : per-bit difference between a captured and a golden table
package tt3_pkg;

  localparam int TT_W  = 8;
  localparam int VEC_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // A set bit marks a vector whose response differs from the golden table.
  function automatic logic [TT_W-1:0] tt_mismatch(
    input logic [TT_W-1:0] captured,
    input logic [TT_W-1:0] golden
  );
    return captured ^ golden;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer used to bring the logic block's output into clk.
// Ports:
//   clk   : destination clock, rising edge
//   rst_n : asynchronous active-low reset, clears both stages
//   i_d   : asynchronous input
//   o_q   : synchronized output (two clk cycles of latency)
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture; the first stage may go metastable, the second resolves it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/tt3_sweep_checker.sv
// Stimulus/check stage for a 3-input truth-table logic block.
// On start it drives vectors 000..111, waits SETTLE_CYCLES per vector, samples
// the block's (synchronized) output, builds an 8-bit truth table and compares
// it with EXPECTED (MSB = response to vector 000).
// Ports:
//   clk, rst_n     : clock and asynchronous active-low reset
//   start          : begin a sweep (honoured only when idle)
//   abort          : synchronous abort back to idle, no done
//   dut_out        : block output, asynchronous to clk
//   in_vec         : stimulus {in1,in2,in3}
//   busy           : sweep in progress (drive/sample/done)
//   done           : one-cycle completion pulse
//   pass           : table_out == EXPECTED, valid from done until next start
//   table_out      : captured table, bit (7-i) = response to vector i
//   mismatch_mask  : table_out ^ EXPECTED
module tt3_sweep_checker
  import tt3_pkg::*;
#(
  parameter int unsigned     SETTLE_CYCLES = 4,
  parameter logic [TT_W-1:0] EXPECTED      = 8'hEB
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             dut_out,
  output logic [VEC_W-1:0] in_vec,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [TT_W-1:0]  table_out,
  output logic [TT_W-1:0]  mismatch_mask
);

  // Counter is loaded with N-1 so DRIVE lasts exactly N cycles including the cnt==0 cycle.
  localparam logic [7:0] CNT_RELOAD = 8'(SETTLE_CYCLES - 1);

  state_t            r_state;
  logic [VEC_W-1:0]  r_idx;
  logic [7:0]        r_cnt;
  logic [VEC_W-1:0]  r_in_vec;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic [TT_W-1:0]   r_table;
  logic [TT_W-1:0]   r_mask;

  logic              w_dut_sync;
  logic [VEC_W-1:0]  w_bit_pos;
  logic [TT_W-1:0]   w_final_table;

  sync2 u_sync2 (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (dut_out),
    .o_q   (w_dut_sync)
  );

  assign w_bit_pos = 3'd7 - r_idx;

  // Table as it will look once the current sample is merged in, so pass/mask
  // can be registered on the same edge as the last capture.
  always_comb begin
    w_final_table            = r_table;
    w_final_table[w_bit_pos] = w_dut_sync;
  end

  // Sweep controller: vector stepping, settle counting, capture and verdict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_idx    <= 3'd0;
      r_cnt    <= 8'd0;
      r_in_vec <= 3'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_table  <= 8'h00;
      r_mask   <= 8'h00;
    end else if (abort) begin
      // Results are left as they are; they are only meaningful after done.
      r_state  <= ST_IDLE;
      r_idx    <= 3'd0;
      r_cnt    <= 8'd0;
      r_in_vec <= 3'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_idx    <= 3'd0;
            r_in_vec <= 3'd0;
            r_cnt    <= CNT_RELOAD;
            r_table  <= 8'h00;
            r_pass   <= 1'b0;
            r_mask   <= 8'h00;
            r_busy   <= 1'b1;
            r_state  <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (r_cnt == 8'd0) begin
            r_state <= ST_SAMPLE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        ST_SAMPLE: begin
          r_table <= w_final_table;
          if (r_idx == 3'd7) begin
            r_done  <= 1'b1;
            r_pass  <= (w_final_table == EXPECTED);
            r_mask  <= tt_mismatch(w_final_table, EXPECTED);
            r_state <= ST_DONE;
          end else begin
            r_idx    <= r_idx + 3'd1;
            r_in_vec <= r_idx + 3'd1;
            r_cnt    <= CNT_RELOAD;
            r_state  <= ST_DRIVE;
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_vec        = r_in_vec;
  assign busy          = r_busy;
  assign done          = r_done;
  assign pass          = r_pass;
  assign table_out     = r_table;
  assign mismatch_mask = r_mask;

endmodule
